conversor_serpar: RTL and testbench

- Parametrised bidirectional serial/parallel converter; next generation of the team's 4-bit serial-to-parallel converter.
- Mode S2P assembles N serial bits into a parallel word.
- Mode P2S serialises a parallel word with a valid/ready handshake.
- 3-bit sideband (A/B/C control lines) travels word-aligned with the data; sits between the serial link pins and the parallel datapath.

---
 rtl/conversor_pkg.sv | 24 ++
 rtl/conversor_shreg.sv | 60 ++++++
 rtl/conversor_serpar.sv | 216 +++++++++++++++++++++
 tb/tb_conversor_serpar.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conversor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conversor_pkg
// Brief   : Shared mode constants, FSM states and counter sizing.
// Revision: 1.0
// ============================================================================
package conversor_pkg;

  localparam logic MODE_S2P = 1'b0;
  localparam logic MODE_P2S = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    S2P_SHIFT = 2'd1,
    P2S_SHIFT = 2'd2
  } state_t;

  // Wide enough to hold N, which also covers the extra parity slot.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conversor_shreg.sv
`default_nettype none
// ============================================================================
// Module  : conversor_shreg
// Brief   : N-bit shift register with clear, parallel load and serial shift.
// Revision: 1.0
// ============================================================================
module conversor_shreg #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         ser_in,
  output logic [N-1:0] q_next,
  output logic         ser_bit
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic [N-1:0] shifted;

  // The same shift direction serves both capture and transmit, so the first
  // serial bit always lands on / leaves from the configured end of the word.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {data_q[N-2:0], ser_in};
      assign ser_bit = data_q[N-1];
    end else begin : g_lsb_first
      assign shifted = {ser_in, data_q[N-1:1]};
      assign ser_bit = data_q[0];
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = shifted;
    end
  end

  assign q_next = data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conversor_serpar.sv
`default_nettype none
// ============================================================================
// Module  : conversor_serpar
// Brief   : Bidirectional serial/parallel converter with word-aligned sideband.
//           Define CONVERSOR_PARITY_EN to append/check an even-parity bit.
// Revision: 1.0
// ============================================================================
module conversor_serpar
  import conversor_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SIDE_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              flush,
  input  logic              ser_in,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_out_en,
  input  logic [N-1:0]      par_in,
  input  logic              par_in_valid,
  output logic              par_in_ready,
  output logic [N-1:0]      par_out,
  output logic              par_out_valid,
  input  logic [SIDE_W-1:0] side_in,
  output logic [SIDE_W-1:0] side_out,
  output logic              par_err,
  output logic              busy
);

`ifdef CONVERSOR_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(L - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
`ifdef CONVERSOR_PARITY_EN
  localparam logic [CW-1:0]  CNT_DATA = CW'(N);
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        par_out_q, par_out_d;
  logic                par_out_valid_q, par_out_valid_d;
  logic [SIDE_W-1:0]   side_out_q, side_out_d;
  logic [SIDE_W-1:0]   side_cap_q, side_cap_d;
  logic                rdy_en_q;
`ifdef CONVERSOR_PARITY_EN
  logic                par_bit_q, par_bit_d;
  logic                par_err_q, par_err_d;
`endif

  logic                sh_load;
  logic                sh_shift;
  logic                sh_bit;
  logic [N-1:0]        sh_next;
  logic                last_bit;
  logic                data_bit;
  logic                accept;

  assign last_bit = (cnt_q == CNT_LAST);
`ifdef CONVERSOR_PARITY_EN
  assign data_bit = (cnt_q < CNT_DATA);
`else
  assign data_bit = 1'b1;
`endif

  // rdy_en_q keeps ready low until the first edge after reset release.
  assign par_in_ready = rdy_en_q && !flush &&
                        ((state_q == IDLE) || ((state_q == P2S_SHIFT) && last_bit));
  assign accept       = par_in_valid && par_in_ready;

  conversor_shreg #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (sh_load),
    .load_val (par_in),
    .shift    (sh_shift),
    .ser_in   (ser_in),
    .q_next   (sh_next),
    .ser_bit  (sh_bit)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    par_out_d       = par_out_q;
    par_out_valid_d = 1'b0;
    side_out_d      = side_out_q;
    side_cap_d      = side_cap_q;
    sh_load         = 1'b0;
    sh_shift        = 1'b0;
`ifdef CONVERSOR_PARITY_EN
    par_bit_d       = par_bit_q;
    par_err_d       = 1'b0;
`endif
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((mode == MODE_S2P) && ser_en) begin
            sh_shift   = 1'b1;
            side_cap_d = side_in;
            cnt_d      = CNT_ONE;
            state_d    = S2P_SHIFT;
          end else if ((mode == MODE_P2S) && accept) begin
            sh_load    = 1'b1;
            side_out_d = side_in;
            cnt_d      = '0;
            state_d    = P2S_SHIFT;
`ifdef CONVERSOR_PARITY_EN
            par_bit_d  = ^par_in;
`endif
          end
        end
        S2P_SHIFT: begin
          if (ser_en) begin
            sh_shift = data_bit;
            if (cnt_q == '0) begin
              side_cap_d = side_in;
            end
            if (last_bit) begin
              // The parity slot does not shift, so sh_next is the data word.
              cnt_d           = '0;
              par_out_d       = sh_next;
              side_out_d      = side_cap_q;
              par_out_valid_d = 1'b1;
`ifdef CONVERSOR_PARITY_EN
              par_err_d       = (^sh_next) ^ ser_in;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
        P2S_SHIFT: begin
          if (last_bit) begin
            cnt_d = '0;
            if (accept) begin
              sh_load    = 1'b1;
              side_out_d = side_in;
`ifdef CONVERSOR_PARITY_EN
              par_bit_d  = ^par_in;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            sh_shift = data_bit;
            cnt_d    = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      par_out_q       <= '0;
      par_out_valid_q <= 1'b0;
      side_out_q      <= '0;
      side_cap_q      <= '0;
      rdy_en_q        <= 1'b0;
`ifdef CONVERSOR_PARITY_EN
      par_bit_q       <= 1'b0;
      par_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      par_out_q       <= par_out_d;
      par_out_valid_q <= par_out_valid_d;
      side_out_q      <= side_out_d;
      side_cap_q      <= side_cap_d;
      rdy_en_q        <= 1'b1;
`ifdef CONVERSOR_PARITY_EN
      par_bit_q       <= par_bit_d;
      par_err_q       <= par_err_d;
`endif
    end
  end

  assign ser_out_en    = (state_q == P2S_SHIFT);
`ifdef CONVERSOR_PARITY_EN
  assign ser_out       = (state_q == P2S_SHIFT) && (data_bit ? sh_bit : par_bit_q);
  assign par_err       = par_err_q;
`else
  assign ser_out       = (state_q == P2S_SHIFT) && sh_bit;
  assign par_err       = 1'b0;
`endif
  assign par_out       = par_out_q;
  assign par_out_valid = par_out_valid_q;
  assign side_out      = side_out_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conversor_serpar.sv
`default_nettype none
// ============================================================================
// Module  : tb_conversor_serpar
// Brief   : Directed bench for two converter instances (N=4 MSB-first and
//           N=8 LSB-first) checked each cycle against a word-level model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conversor_serpar;

`ifdef CONVERSOR_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L1 = 8 + PB;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [1:0] mode   = '0;
  logic [1:0] flush  = '0;
  logic [1:0] ser_in = '0;
  logic [1:0] ser_en = '0;
  logic [1:0] pvalid = '0;
  logic [7:0] pin [2];
  logic [2:0] sin [2];

  wire  [1:0] sout, soen, prdy, pval, perr, busy_w;
  wire  [3:0] pout0;
  wire  [7:0] pout1;
  wire  [2:0] sside0, sside1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conversor_serpar #(.N(4), .MSB_FIRST(1'b1), .SIDE_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode[0]), .flush(flush[0]),
    .ser_in(ser_in[0]), .ser_en(ser_en[0]), .ser_out(sout[0]), .ser_out_en(soen[0]),
    .par_in(pin[0][3:0]), .par_in_valid(pvalid[0]), .par_in_ready(prdy[0]),
    .par_out(pout0), .par_out_valid(pval[0]), .side_in(sin[0]), .side_out(sside0),
    .par_err(perr[0]), .busy(busy_w[0]));

  conversor_serpar #(.N(8), .MSB_FIRST(1'b0), .SIDE_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode[1]), .flush(flush[1]),
    .ser_in(ser_in[1]), .ser_en(ser_en[1]), .ser_out(sout[1]), .ser_out_en(soen[1]),
    .par_in(pin[1]), .par_in_valid(pvalid[1]), .par_in_ready(prdy[1]),
    .par_out(pout1), .par_out_valid(pval[1]), .side_in(sin[1]), .side_out(sside1),
    .par_err(perr[1]), .busy(busy_w[1]));

  task automatic chk(input int k, input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL t=%0t dut%0d %s got=%0h expected=%0h", $time, k, nm, a, e);
    end
  endtask

  // ---------------- word-level reference model ----------------
  int         ph  [2];   // 0 idle, 1 receiving, 2 transmitting
  int         nb  [2];
  int         txi [2];
  logic [8:0] rxb [2];
  logic [2:0] scap[2];
  logic [2:0] e_side[2];
  logic [7:0] e_pout[2];
  logic [7:0] txw [2];
  logic       e_val[2], e_err[2], ren[2];

  function automatic int nfor(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int lfor(input int k);
    return nfor(k) + PB;
  endfunction

  function automatic logic txbit(input int k, input int i);
    if (i < nfor(k)) return txw[k][(k == 0) ? nfor(k) - 1 - i : i];
    return ^txw[k];
  endfunction

  task automatic model_reset(input int k);
    ph[k] = 0; nb[k] = 0; txi[k] = 0; rxb[k] = '0; scap[k] = '0;
    e_side[k] = '0; e_pout[k] = '0; txw[k] = '0;
    e_val[k] = 1'b0; e_err[k] = 1'b0; ren[k] = 1'b0;
  endtask

  task automatic take(input int k);
    logic [7:0] w;
    if (nb[k] == 0) scap[k] = sin[k];
    rxb[k][nb[k]] = ser_in[k];
    nb[k]++;
    if (nb[k] == lfor(k)) begin
      w = '0;
      for (int i = 0; i < nfor(k); i++) w[(k == 0) ? nfor(k) - 1 - i : i] = rxb[k][i];
      e_pout[k] = w;
      e_side[k] = scap[k];
      e_val[k]  = 1'b1;
      e_err[k]  = (PB == 1) ? ((^w) ^ rxb[k][nfor(k)]) : 1'b0;
      nb[k]     = 0;
    end
  endtask

  task automatic load(input int k);
    txw[k]    = (k == 0) ? {4'b0, pin[k][3:0]} : pin[k];
    txi[k]    = 0;
    e_side[k] = sin[k];
    ph[k]     = 2;
  endtask

  function automatic logic ready_exp(input int k);
    return ren[k] && !flush[k] && (ph[k] == 0 || (ph[k] == 2 && txi[k] == lfor(k) - 1));
  endfunction

  task automatic model_step(input int k);
    logic rp;
    rp = ready_exp(k);
    e_val[k] = 1'b0;
    e_err[k] = 1'b0;
    if (flush[k]) begin
      ph[k] = 0; nb[k] = 0; txi[k] = 0;
    end else if (ph[k] == 0) begin
      if (!mode[k] && ser_en[k]) begin
        take(k);
        ph[k] = 1;
      end else if (mode[k] && pvalid[k] && rp) begin
        load(k);
      end
    end else if (ph[k] == 1) begin
      if (ser_en[k]) take(k);
      else if (nb[k] == 0) ph[k] = 0;
    end else begin
      if (txi[k] == lfor(k) - 1) begin
        if (pvalid[k] && rp) load(k);
        else begin ph[k] = 0; txi[k] = 0; end
      end else begin
        txi[k]++;
      end
    end
    ren[k] = 1'b1;
  endtask

  task automatic compare(input int k);
    logic [7:0] ap;
    logic [2:0] as;
    ap = (k == 0) ? {4'b0, pout0} : pout1;
    as = (k == 0) ? sside0 : sside1;
    chk(k, "par_out", ap, e_pout[k]);
    chk(k, "par_out_valid", pval[k], e_val[k]);
    chk(k, "par_err", perr[k], e_err[k]);
    chk(k, "side_out", as, e_side[k]);
    chk(k, "busy", busy_w[k], ph[k] != 0);
    chk(k, "ser_out_en", soen[k], ph[k] == 2);
    chk(k, "ser_out", sout[k], (ph[k] == 2) ? txbit(k, txi[k]) : 1'b0);
    chk(k, "par_in_ready", prdy[k], ready_exp(k));
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
    end
    #1;
    for (int k = 0; k < 2; k++) compare(k);
  end

  // ---------------- directed stimulus ----------------
  logic [8:0] got;
  logic [8:0] got2;
  logic [6:0] gen, gd, gm;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic s2p_word(input logic [3:0] w, input logic [2:0] sd, input logic flip);
    mode[0]   = 1'b0;
    ser_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin[0]    = (i == 0) ? sd : ~sd;
      ser_in[0] = w[3-i];
      step();
    end
    if (PB == 1) begin
      ser_in[0] = (^w) ^ flip;
      step();
    end
    ser_en[0] = 1'b0;
    ser_in[0] = 1'b0;
    sin[0]    = '0;
  endtask

  initial begin
    pin[0] = '0; pin[1] = '0; sin[0] = '0; sin[1] = '0;
    #2 rst_n = 1'b0;
    step(); step();
    chk(0, "rst_ready_low", prdy[0], 1'b0);
    chk(1, "rst_busy_low", busy_w[1], 1'b0);
    rst_n = 1'b1;
    step();
    chk(0, "ready_after_rst", prdy[0], 1'b1);
    chk(1, "ready_after_rst", prdy[1], 1'b1);

    // S2P basic word with sideband captured on bit 0
    s2p_word(4'b1011, 3'b101, 1'b0);
    chk(0, "t1_par_out", pout0, 4'b1011);
    chk(0, "t1_side_out", sside0, 3'b101);
    chk(0, "t1_valid", pval[0], 1'b1);
    step();
    chk(0, "t1_valid_one_cycle", pval[0], 1'b0);
    chk(0, "t1_back_idle", busy_w[0], 1'b0);

    // S2P with ser_en gaps; mode/par_in_valid toggled mid-word
    gen = 7'b1001101; gd = 7'b1110011; gm = 7'b0011000;
    pin[0] = 8'h0F;
    for (int i = 0; i < 7; i++) begin
      ser_en[0] = gen[6-i]; ser_in[0] = gd[6-i];
      mode[0] = gm[6-i]; pvalid[0] = gm[6-i];
      step();
    end
    if (PB == 1) begin ser_en[0] = 1'b1; ser_in[0] = 1'b0; step(); end
    ser_en[0] = 1'b0; ser_in[0] = 1'b0; mode[0] = 1'b0; pvalid[0] = 1'b0; pin[0] = '0;
    chk(0, "gap_par_out", pout0, 4'b1001);
    chk(0, "gap_valid", pval[0], 1'b1);
    step();

    // Flush after two bits, then a full word
    ser_en[0] = 1'b1; ser_in[0] = 1'b1;
    step(); step();
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0; ser_en[0] = 1'b0; ser_in[0] = 1'b0;
    chk(0, "flush_idle", busy_w[0], 1'b0);
    chk(0, "flush_no_pulse", pval[0], 1'b0);
    s2p_word(4'b0110, 3'b010, 1'b0);
    chk(0, "flush_next_word", pout0, 4'b0110);
    step();

    // P2S LSB-first 0xA5 then back-to-back 0x3C
    mode[1] = 1'b1; pin[1] = 8'hA5; sin[1] = 3'b011; pvalid[1] = 1'b1;
    step();
    pvalid[1] = 1'b0; pin[1] = '0; sin[1] = '0;
    chk(1, "a5_side_out", sside1, 3'b011);
    got = '0;
    for (int i = 0; i < L1; i++) begin
      got[i] = sout[1];
      if (i == L1 - 1) begin
        chk(1, "a5_ready_last_bit", prdy[1], 1'b1);
        pin[1] = 8'h3C; pvalid[1] = 1'b1; sin[1] = 3'b110;
      end
      step();
    end
    pvalid[1] = 1'b0; pin[1] = '0; sin[1] = '0;
    chk(1, "a5_serial_bits", got[7:0], 8'hA5);
    chk(1, "b2b_no_gap", soen[1], 1'b1);
    got2 = '0;
    for (int i = 0; i < L1; i++) begin
      got2[i] = sout[1];
      step();
    end
    chk(1, "3c_serial_bits", got2[7:0], 8'h3C);
    chk(1, "p2s_done_en", soen[1], 1'b0);

    // Flush beats a handshake in the final bit cycle
    pin[1] = 8'h81; pvalid[1] = 1'b1;
    step();
    pvalid[1] = 1'b0;
    repeat (L1 - 1) step();
    flush[1] = 1'b1; pvalid[1] = 1'b1; pin[1] = 8'h42;
    #1 chk(1, "flush_ready_low", prdy[1], 1'b0);
    step();
    flush[1] = 1'b0; pvalid[1] = 1'b0; pin[1] = '0;
    chk(1, "flush_p2s_en", soen[1], 1'b0);
    chk(1, "flush_p2s_busy", busy_w[1], 1'b0);
    step();

    // Asynchronous reset in the middle of a P2S word
    pin[1] = 8'hFF; pvalid[1] = 1'b1;
    step();
    pvalid[1] = 1'b0; pin[1] = '0;
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk(1, "rst_mid_en", soen[1], 1'b0);
    chk(1, "rst_mid_busy", busy_w[1], 1'b0);
    chk(0, "rst_mid_par_out", pout0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    chk(1, "ready_after_rst2", prdy[1], 1'b1);
    mode[1] = 1'b0;

`ifdef CONVERSOR_PARITY_EN
    s2p_word(4'b1101, 3'b001, 1'b1);
    chk(0, "par_bad_word", pout0, 4'b1101);
    chk(0, "par_bad_err", perr[0], 1'b1);
    step();
    chk(0, "par_err_pulse_end", perr[0], 1'b0);
    s2p_word(4'b1101, 3'b001, 1'b0);
    chk(0, "par_good_err", perr[0], 1'b0);
    step();
    mode[0] = 1'b1; pin[0] = 8'h0D; pvalid[0] = 1'b1;
    step();
    pvalid[0] = 1'b0; pin[0] = '0;
    got = '0;
    for (int i = 0; i < 5; i++) begin
      got = {got[7:0], sout[0]};
      step();
    end
    chk(0, "par_p2s_bits", {3'b0, got[4:0]}, 8'h1B);
    mode[0] = 1'b0;
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
